sram_banked_unaligned: RTL and testbench

- Parametrised successor to the two-bank 64-bit scratchpad.
- Generalised to N_BANKS word-interleaved banks of WORD_WIDTH bits.
- Adds an independent write port (word-addressed, byte-enabled) and a read port (byte-addressed, unaligned) in the same cycle, with 2-stage read pipeline, valid flag, end-of-memory wrap and range-error reporting.
- Sits between the NPU DMA/load unit and the compute datapath as the operand scratchpad.

---
 rtl/sram_banked_unaligned.sv | 173 +++++++++++++++++
 tb/tb_sram_banked_unaligned.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_banked_unaligned.sv
// sram_banked_unaligned: operand scratchpad made of N_BANKS word-interleaved
// banks. It has one write port and one read port, and both can be used in the
// same cycle.
//   Write port: word-addressed, byte-enabled, single cycle.
//   Read port:  byte-addressed, any alignment, 2-cycle fixed latency,
//               1 read/cycle.
//   Range:      out-of-range accesses raise err_o one cycle later.
//               Out-of-range reads return zero data with a valid pulse.
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   wr_en_i, wr_addr_i       write strobe, word address
//   wr_be_i, wr_data_i       byte enables, little-endian write data
//   rd_en_i, rd_addr_i       read request, byte address
//   rd_data_o, rd_valid_o    read data (held between pulses), valid pulse
//   err_o                    out-of-range pulse (write or read, merged)

// One bank: a plain byte-writable RAM with a registered, read-first output.
// It has no reset, so it can map onto block RAM.
module sram_bank #(
    parameter int BYTES = 8,
    parameter int ROWS  = 512,
    parameter int ROW_W = 9
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ROW_W-1:0]   waddr_i,
    input  logic [BYTES-1:0]   wbe_i,
    input  logic [BYTES*8-1:0] wdata_i,
    input  logic               re_i,
    input  logic [ROW_W-1:0]   raddr_i,
    output logic [BYTES*8-1:0] rdata_o
);
    logic [BYTES*8-1:0] mem [ROWS];
    logic [BYTES*8-1:0] rdata_q;

    // The read and the write sit in the same block with non-blocking
    // assignment, so a same-row collision returns the old data.
    always_ff @(posedge clk_i) begin
        if (re_i) rdata_q <= mem[raddr_i];
        for (int k = 0; k < BYTES; k++)
            if (we_i && wbe_i[k]) mem[waddr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
    end

    assign rdata_o = rdata_q;
endmodule

module sram_banked_unaligned #(
    parameter int WORD_WIDTH = 64,
    parameter int N_BANKS    = 2,
    parameter int N_ENTRIES  = 1024,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    wr_en_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [WORD_WIDTH/8-1:0] wr_be_i,
    input  logic [WORD_WIDTH-1:0]   wr_data_i,
    input  logic                    rd_en_i,
    input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
    output logic [WORD_WIDTH-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    output logic                    err_o
);
    localparam int BYTES  = WORD_WIDTH / 8;
    localparam int OFF_W  = $clog2(BYTES);
    localparam int ROWS   = N_ENTRIES / N_BANKS;
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BANK_W = $clog2(N_BANKS);

    localparam logic [ADDR_WIDTH-1:0] N_ENT_A     = ADDR_WIDTH'(N_ENTRIES);
    localparam logic [ADDR_WIDTH-1:0] LAST_W_A    = ADDR_WIDTH'(N_ENTRIES - 1);
    localparam logic [ADDR_WIDTH-1:0] MEM_BYTES_A = ADDR_WIDTH'(N_ENTRIES * BYTES);
    localparam logic [ADDR_WIDTH-1:0] BYTES_A     = ADDR_WIDTH'(BYTES);
    localparam logic [ADDR_WIDTH-1:0] NB_A        = ADDR_WIDTH'(N_BANKS);
    localparam logic [ADDR_WIDTH-1:0] ONE_A       = ADDR_WIDTH'(1);

    // Request decode (cycle T)
    logic                  wr_ok, wr_err, rd_err;
    logic [BANK_W-1:0]     wr_bank, b0, b1;
    logic [ROW_W-1:0]      wr_row, row0, row1;
    logic [ADDR_WIDTH-1:0] w0, w1;
    logic [OFF_W-1:0]      off;

    logic [N_BANKS-1:0]                 bank_we;
    logic [N_BANKS-1:0][ROW_W-1:0]      bank_raddr;
    logic [N_BANKS-1:0][WORD_WIDTH-1:0] bank_rdata;

    // Pipeline state
    logic [1:0]            vld_pipe_q, vld_pipe_d;
    logic                  rerr_q, rerr_d;
    logic                  err_q, err_d;
    logic [OFF_W-1:0]      off_q, off_d;
    logic [BANK_W-1:0]     b0_q, b0_d;
    logic [WORD_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        wr_err  = wr_en_i && (wr_addr_i >= N_ENT_A);
        wr_ok   = wr_en_i && (wr_addr_i < N_ENT_A);
        wr_bank = BANK_W'(wr_addr_i % NB_A);
        wr_row  = ROW_W'(wr_addr_i / NB_A);

        rd_err  = rd_en_i && (rd_addr_i >= MEM_BYTES_A);
        w0      = rd_addr_i / BYTES_A;
        off     = OFF_W'(rd_addr_i % BYTES_A);
        w1      = (w0 == LAST_W_A) ? '0 : w0 + ONE_A;
        b0      = BANK_W'(w0 % NB_A);
        row0    = ROW_W'(w0 / NB_A);
        row1    = ROW_W'(w1 / NB_A);

        // w0 and w1 always live in different banks, so each bank serves at
        // most one of them. Banks that hold neither word get row1, which is
        // unused.
        for (int b = 0; b < N_BANKS; b++) begin
            bank_we[b]    = wr_ok && (wr_bank == BANK_W'(b));
            bank_raddr[b] = (b0 == BANK_W'(b)) ? row0 : row1;
        end
    end

    for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
        sram_bank #(.BYTES(BYTES), .ROWS(ROWS), .ROW_W(ROW_W)) u_bank (
            .clk_i   (clk_i),
            .we_i    (bank_we[g]),
            .waddr_i (wr_row),
            .wbe_i   (wr_be_i),
            .wdata_i (wr_data_i),
            .re_i    (rd_en_i),
            .raddr_i (bank_raddr[g]),
            .rdata_o (bank_rdata[g])
        );
    end

    // Funnel stage (cycle T+1). Because N_BANKS is a power of 2, adding 1 in
    // BANK_W bits wraps modulo N_BANKS. That matches the memory-end wrap,
    // since word N_ENTRIES-1 is in the last bank and word 0 is in bank 0.
    logic [2*WORD_WIDTH-1:0] pair;

    always_comb begin
        b1   = b0_q + BANK_W'(1);
        pair = {bank_rdata[b1], bank_rdata[b0_q]};

        vld_pipe_d = {vld_pipe_q[0], rd_en_i};
        rerr_d     = rd_err;
        err_d      = wr_err || rd_err;
        off_d      = off;
        b0_d       = b0;
        rd_data_d  = rd_data_q;
        if (vld_pipe_q[0])
            rd_data_d = rerr_q ? '0 : pair[{off_q, 3'b000} +: WORD_WIDTH];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_pipe_q <= '0;
            rerr_q     <= 1'b0;
            err_q      <= 1'b0;
            off_q      <= '0;
            b0_q       <= '0;
            rd_data_q  <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            rerr_q     <= rerr_d;
            err_q      <= err_d;
            off_q      <= off_d;
            b0_q       <= b0_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = vld_pipe_q[1];
    assign err_o      = err_q;
endmodule

// File: tb/tb_sram_banked_unaligned.sv
// Testbench for sram_banked_unaligned. It keeps a word-array model of the
// memory and, at each clock edge, works out the expected outputs from the
// request at that edge. The outputs are compared on every falling edge.
// Directed literal checks pin the model to known values.
module tb_sram_banked_unaligned;
    localparam int NE = 1024;
    localparam int MB = NE * 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [7:0]  wr_be = '0;
    logic [63:0] wr_data = '0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [63:0] rd_data;
    logic        rd_valid;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_banked_unaligned #(
        .WORD_WIDTH(64), .N_BANKS(2), .N_ENTRIES(NE), .ADDR_WIDTH(32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_be_i    (wr_be),
        .wr_data_i  (wr_data),
        .rd_en_i    (rd_en),
        .rd_addr_i  (rd_addr),
        .rd_data_o  (rd_data),
        .rd_valid_o (rd_valid),
        .err_o      (err)
    );

    // Behavioural model
    logic [63:0] mem_m [0:NE-1];
    logic        exp_v = 1'b0, exp_err = 1'b0, pend_v = 1'b0;
    logic [63:0] exp_d = '0, pend_d = '0;

    function automatic logic [63:0] model_read(input logic [31:0] a);
        logic [127:0] pr;
        int w0, w1, off;
        if (a >= MB) return 64'h0;
        w0  = int'(a / 8);
        off = int'(a % 8);
        w1  = (w0 + 1) % NE;
        pr  = {mem_m[w1], mem_m[w0]};
        return pr[off*8 +: 64];
    endfunction

    // After each edge: err reflects this edge's request; valid/data reflect the
    // previous edge's read. The model reads before it writes (read-first).
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_v = 1'b0; exp_err = 1'b0; exp_d = '0; pend_v = 1'b0;
        end else begin
            exp_v = pend_v;
            if (pend_v) exp_d = pend_d;
            exp_err = (wr_en && wr_addr >= NE) || (rd_en && rd_addr >= MB);
            pend_v = rd_en;
            if (rd_en) pend_d = model_read(rd_addr);
            if (wr_en && wr_addr < NE)
                for (int k = 0; k < 8; k++)
                    if (wr_be[k]) mem_m[wr_addr[9:0]][k*8 +: 8] = wr_data[k*8 +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic check_outputs();
        chk("rd_valid", {63'b0, rd_valid}, {63'b0, exp_v});
        chk("err", {63'b0, err}, {63'b0, exp_err});
        chk("rd_data", rd_data, exp_d);
    endtask

    task automatic cyc(input logic we, input logic [31:0] wa, input logic [7:0] be,
                       input logic [63:0] wd, input logic re, input logic [31:0] ra);
        @(negedge clk);
        check_outputs();
        wr_en = we; wr_addr = wa; wr_be = be; wr_data = wd;
        rd_en = re; rd_addr = ra;
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 8'h00, 64'd0, 1'b0, 32'd0);
    endtask

    task automatic rd(input logic [31:0] a);
        cyc(1'b0, 32'd0, 8'h00, 64'd0, 1'b1, a);
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] be, input logic [63:0] d);
        cyc(1'b1, a, be, d, 1'b0, 32'd0);
    endtask

    localparam logic [63:0] W0 = 64'h0706050403020100;
    localparam logic [63:0] W1 = 64'h0F0E0D0C0B0A0908;

    initial begin
        logic [31:0] a;
        int r;

        // Reset state
        repeat (3) idle();
        chk("reset_valid", {63'b0, rd_valid}, 64'd0);
        chk("reset_data", rd_data, 64'd0);
        chk("reset_err", {63'b0, err}, 64'd0);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;

        // Fill the whole memory so that every read has a defined value
        for (int w = 0; w < NE; w++) wr(w, 8'hFF, {$urandom, $urandom});

        // Unaligned read
        wr(0, 8'hFF, W0);
        wr(1, 8'hFF, W1);
        rd(3);
        idle(); chk("unaligned_err", {63'b0, err}, 64'd0);
        idle(); chk("unaligned_valid", {63'b0, rd_valid}, 64'd1);
        chk("unaligned_data", rd_data, 64'h0A09080706050403);

        // Byte enables
        wr(2, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        wr(2, 8'h0F, 64'h0);
        rd(16);
        idle(); idle();
        chk("byte_en_data", rd_data, 64'hFFFFFFFF00000000);

        // Wrap from the last word back to word 0
        wr(1023, 8'hFF, 64'h8877665544332211);
        rd(8188);
        idle(); chk("wrap_err", {63'b0, err}, 64'd0);
        idle(); chk("wrap_data", rd_data, 64'h0302010088776655);

        // Read/write collision is read-first
        wr(5, 8'hFF, {8{8'hAA}});
        cyc(1'b1, 32'd5, 8'hFF, {8{8'h55}}, 1'b1, 32'd40);
        rd(40);
        idle(); chk("collide_old", rd_data, {8{8'hAA}});
        idle(); chk("collide_new", rd_data, {8{8'h55}});

        // Streaming, one byte of shift per read
        rd(0); rd(1); rd(2);
        chk("stream0", rd_data, 64'h0706050403020100);
        rd(3);
        chk("stream1", rd_data, 64'h0807060504030201);
        idle(); chk("stream2", rd_data, 64'h0908070605040302);
        chk("stream2_valid", {63'b0, rd_valid}, 64'd1);
        idle(); chk("stream3", rd_data, 64'h0A09080706050403);
        idle(); chk("stream_end_valid", {63'b0, rd_valid}, 64'd0);

        // Range errors
        wr(1024, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF);
        idle(); chk("wr_range_err", {63'b0, err}, 64'd1);
        rd(0);
        idle(); idle(); chk("wr_range_w0", rd_data, W0);
        rd(8192);
        idle(); chk("rd_range_err", {63'b0, err}, 64'd1);
        idle(); chk("rd_range_valid", {63'b0, rd_valid}, 64'd1);
        chk("rd_range_data", rd_data, 64'd0);
        cyc(1'b1, 32'd2000, 8'hFF, 64'd1, 1'b1, 32'd9000);
        idle(); chk("both_err", {63'b0, err}, 64'd1);
        idle(); chk("both_err_single", {63'b0, err}, 64'd0);

        // Reset in the middle of a read stream
        rd(0); rd(1);
        @(negedge clk);
        check_outputs();
        chk("pre_rst_valid", {63'b0, rd_valid}, 64'd1);
        rst_n = 1'b0; rd_en = 1'b1; rd_addr = 32'd2;
        #1;
        chk("rst_valid_drop", {63'b0, rd_valid}, 64'd0);
        chk("rst_data_clear", rd_data, 64'd0);
        rd(3); rd(4);
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1; rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post_rst_no_valid", {63'b0, rd_valid}, 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic we, re;
            logic [31:0] wa;
            we = 1'($urandom % 2);
            r = int'($urandom % 10);
            wa = (r == 0) ? 32'd1024 + ($urandom % 64) : (r == 1) ? $urandom : $urandom % NE;
            re = ($urandom % 10) < 7;
            r = int'($urandom % 10);
            a = (r == 0) ? 32'd8192 + ($urandom % 64) :
                (r == 1) ? $urandom :
                (r == 2) ? 32'd8176 + ($urandom % 16) : $urandom % MB;
            cyc(we, wa, 8'($urandom), {$urandom, $urandom}, re, a);
        end
        repeat (3) idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
